// File: rtl/imem_write_arbiter.sv
// imem_write_arbiter: round-robin owner of the instruction-memory write port for two producers,
// holding the write pointer and issuing one start/done memory write per accepted word.
module imem_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] ADDR_LIMIT = 16'hFFFF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_grant,
  input  logic                  req1_valid,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_grant,
  input  logic                  addr_load,
  input  logic [ADDR_WIDTH-1:0] addr_load_value,
  output logic                  mem_start,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data,
  input  logic                  mem_done,
  output logic                  busy,
  output logic                  full,
  output logic                  last_grant,
  output logic [ADDR_WIDTH-1:0] write_count
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_MEM} state_t;
  state_t state, state_n;
  logic [ADDR_WIDTH-1:0] ptr, ptr_n, addr_n, count_n;
  logic [DATA_WIDTH-1:0] data_n;
  logic full_n, last_n, g0_n, g1_n, start_n, pick1;
  // producer 1 wins when alone, or when both ask and producer 0 was served last
  assign pick1 = req1_valid && (!req0_valid || !last_grant);
  always_comb begin
    state_n = state;
    ptr_n = ptr;
    count_n = write_count;
    full_n = full;
    addr_n = mem_address;
    data_n = mem_data;
    last_n = last_grant;
    g0_n = 1'b0;
    g1_n = 1'b0;
    start_n = 1'b0;
    case (state)
      IDLE:
        if (addr_load) begin
          ptr_n = addr_load_value;
          full_n = 1'b0;
          count_n = '0;
        end else if (!full && (req0_valid || req1_valid)) begin
          data_n = pick1 ? req1_data : req0_data;
          addr_n = ptr;
          last_n = pick1;
          g0_n = !pick1;
          g1_n = pick1;
          start_n = 1'b1;
          state_n = ISSUE;
        end
      ISSUE: state_n = WAIT_MEM;
      WAIT_MEM:
        if (mem_done) begin
          ptr_n = ptr + ADDR_WIDTH'(1);
          count_n = write_count + ADDR_WIDTH'(1);
          full_n = mem_address == ADDR_LIMIT;
          state_n = IDLE;
        end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ptr <= '0;
      write_count <= '0;
      full <= 1'b0;
      mem_address <= '0;
      mem_data <= '0;
      last_grant <= 1'b1;
      req0_grant <= 1'b0;
      req1_grant <= 1'b0;
      mem_start <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      write_count <= count_n;
      full <= full_n;
      mem_address <= addr_n;
      mem_data <= data_n;
      last_grant <= last_n;
      req0_grant <= g0_n;
      req1_grant <= g1_n;
      mem_start <= start_n;
      busy <= state_n != IDLE;
    end
  end
endmodule

// File: tb/tb_imem_write_arbiter.sv
// tb_imem_write_arbiter: directed stimulus against a transaction-level model of the write arbiter.
module tb_imem_write_arbiter;
  logic clk = 1'b0, reset = 1'b1;
  logic req0_valid = 1'b0, req1_valid = 1'b0, addr_load = 1'b0, mem_done = 1'b0;
  logic [31:0] req0_data = '0, req1_data = '0, mem_data;
  logic [15:0] addr_load_value = '0, mem_address, write_count;
  logic req0_grant, req1_grant, mem_start, busy, full, last_grant;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  imem_write_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_grant(req0_grant),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_grant(req1_grant),
    .addr_load(addr_load), .addr_load_value(addr_load_value),
    .mem_start(mem_start), .mem_address(mem_address), .mem_data(mem_data), .mem_done(mem_done),
    .busy(busy), .full(full), .last_grant(last_grant), .write_count(write_count)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask
  // Model: a transaction is open from acceptance until its done; grant/strobe fill its first
  // cycle, and done counts only once that first cycle is over.
  logic m_open, m_last, m_full;
  int m_age;
  logic [15:0] m_ptr, m_cnt, m_addr;
  logic [31:0] m_data;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_open <= 1'b0; m_age <= 0; m_last <= 1'b1; m_full <= 1'b0;
      m_ptr <= '0; m_cnt <= '0; m_addr <= '0; m_data <= '0;
    end else if (!m_open) begin
      if (addr_load) begin
        m_ptr <= addr_load_value; m_full <= 1'b0; m_cnt <= '0;
      end else if (!m_full && (req0_valid || req1_valid)) begin
        m_last <= req1_valid && !(req0_valid && m_last);
        m_data <= (req1_valid && !(req0_valid && m_last)) ? req1_data : req0_data;
        m_addr <= m_ptr; m_open <= 1'b1; m_age <= 0;
      end
    end else begin
      m_age <= m_age + 1;
      if (m_age >= 1 && mem_done) begin
        m_open <= 1'b0; m_ptr <= m_ptr + 16'd1; m_cnt <= m_cnt + 16'd1;
        m_full <= m_addr == 16'hFFFF;
      end
    end
  end
  always @(negedge clk) if (!reset) begin
    check("grant0", 32'(req0_grant), 32'(m_open && m_age == 0 && !m_last));
    check("grant1", 32'(req1_grant), 32'(m_open && m_age == 0 && m_last));
    check("mem_start", 32'(mem_start), 32'(m_open && m_age == 0));
    check("busy", 32'(busy), 32'(m_open));
    check("full", 32'(full), 32'(m_full));
    check("last_grant", 32'(last_grant), 32'(m_last));
    check("mem_address", 32'(mem_address), 32'(m_addr));
    check("mem_data", mem_data, m_data);
    check("write_count", 32'(write_count), 32'(m_cnt));
  end
  logic s_g0, s_g1;
  logic [15:0] s_addr;
  logic [31:0] s_data;
  logic g_log[$];
  logic [15:0] a_log[$];
  task automatic wait_start(input bit drop);
    int t = 0;
    while (!mem_start && t < 20) begin @(negedge clk); t++; end
    check("start_seen", 32'(mem_start), 32'd1);
    s_g0 = req0_grant; s_g1 = req1_grant; s_addr = mem_address; s_data = mem_data;
    g_log.push_back(req1_grant); a_log.push_back(mem_address);
    if (drop && req0_grant) req0_valid = 1'b0;
    if (drop && req1_grant) req1_valid = 1'b0;
  endtask
  task automatic serve(input int d, input bit drop);
    wait_start(drop);
    repeat (d) begin
      @(negedge clk);
      check("hold_addr", 32'(mem_address), 32'(s_addr));
      check("busy_wait", 32'(busy), 32'd1);
    end
    mem_done = 1'b1; @(negedge clk); mem_done = 1'b0;
  endtask
  task automatic load(input logic [15:0] v);
    addr_load = 1'b1; addr_load_value = v; @(negedge clk); addr_load = 1'b0;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_last", 32'(last_grant), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    req0_data = 32'h9201_04E0; req0_valid = 1'b1;
    serve(1, 1);
    check("t1_g0", 32'(s_g0), 32'd1);
    check("t1_g1", 32'(s_g1), 32'd0);
    check("t1_addr", 32'(s_addr), 32'd0);
    check("t1_data", s_data, 32'h9201_04E0);
    check("t1_count", 32'(write_count), 32'd1);
    req1_data = 32'h1111_2222; req1_valid = 1'b1;
    serve(1, 1);
    check("t1_next_addr", 32'(s_addr), 32'd1);
    check("t1_next_g1", 32'(s_g1), 32'd1);
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    g_log.delete(); a_log.delete();
    req0_data = 32'hA0A0_0000; req1_data = 32'hB1B1_1111;
    req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (4) serve(1, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("rr_order", 32'(g_log[i]), 32'(i % 2));
      check("rr_addr", 32'(a_log[i]), 32'(i));
    end
    check("rr_last", 32'(last_grant), 32'd1);
    load(16'hFFFE);
    req0_valid = 1'b1;
    serve(1, 0);
    check("wrap_addr0", 32'(s_addr), 32'h0000_FFFE);
    serve(1, 1);
    check("wrap_addr1", 32'(s_addr), 32'h0000_FFFF);
    check("wrap_full", 32'(full), 32'd1);
    check("wrap_count", 32'(write_count), 32'd2);
    req1_valid = 1'b1;
    repeat (5) begin @(negedge clk); check("full_nogrant", 32'(req1_grant), 32'd0); end
    load(16'h0010);
    check("lp_nogrant", 32'(req1_grant), 32'd0);
    check("lp_full", 32'(full), 32'd0);
    check("lp_count", 32'(write_count), 32'd0);
    serve(1, 1);
    check("lp_g1", 32'(s_g1), 32'd1);
    check("lp_addr", 32'(s_addr), 32'h0000_0010);
    req0_data = 32'h3C3C_5A5A; req0_valid = 1'b1;
    serve(10, 1);
    check("stall_addr", 32'(s_addr), 32'h0000_0011);
    check("stall_data", s_data, 32'h3C3C_5A5A);
    check("stall_count", 32'(write_count), 32'd2);
    mem_done = 1'b1; @(negedge clk); mem_done = 1'b0; @(negedge clk);
    check("stray_count", 32'(write_count), 32'd2);
    req1_valid = 1'b1;
    serve(1, 1);
    check("stray_addr", 32'(s_addr), 32'h0000_0012);
    req0_data = 32'hDEAD_BEEF; req0_valid = 1'b1;
    wait_start(0);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_addr", 32'(mem_address), 32'd0);
    check("arst_data", mem_data, 32'd0);
    check("arst_last", 32'(last_grant), 32'd1);
    check("arst_count", 32'(write_count), 32'd0);
    check("arst_start", 32'(mem_start), 32'd0);
    @(negedge clk); reset = 1'b0;
    serve(1, 1);
    check("arst_regrant", 32'(s_g0), 32'd1);
    check("arst_readdr", 32'(s_addr), 32'd0);
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
